// File: rtl/serializer_tx_sched.sv
// Two-requester round-robin scheduler feeding a parallel-load serializer.
// Each loaded word occupies WIDTH cycles. Empty slots get SYNC_WORD filler or leave the block idle.
`timescale 1ns/1ps
module serializer_tx_sched #(
    parameter int               WIDTH     = 8,
    parameter int               LOG_WIDTH = 3,
    parameter logic [WIDTH-1:0] SYNC_WORD = 8'hBC
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             sync_en,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req0_ready,
    output logic             req1_ready,
    output logic             ser_load,
    output logic [WIDTH-1:0] ser_din,
    output logic             grant_id,
    output logic             is_sync,
    output logic             busy,
    output logic [15:0]      word_count
);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    state_t                 r_state;
    logic [LOG_WIDTH-1:0]   r_cnt;
    logic                   r_last;      // 1 = req1 was granted last
    logic                   r_ser_load;
    logic [WIDTH-1:0]       r_ser_din;
    logic                   r_grant_id;
    logic                   r_is_sync;
    logic [15:0]            r_word_count;

    logic w_decide;
    logic w_any;
    logic w_gnt;
    logic w_take;

    assign w_decide = (r_state == ST_IDLE) || (r_cnt == '0);
    assign w_any    = req0_valid | req1_valid;
    // On contention the requester not granted last wins; a lone requester always wins.
    assign w_gnt    = (req0_valid & req1_valid) ? ~r_last : req1_valid;
    assign w_take   = w_decide & w_any;

    // NOTE: ready is combinational, so it is gated by reset_n directly; the
    // registered state alone would still present a decision cycle during reset.
    assign req0_ready = reset_n & w_take & ~w_gnt;
    assign req1_ready = reset_n & w_take &  w_gnt;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_last       <= 1'b1;
            r_ser_load   <= 1'b0;
            r_ser_din    <= '0;
            r_grant_id   <= 1'b0;
            r_is_sync    <= 1'b0;
            r_word_count <= '0;
        end else begin
            // NOTE: default low makes ser_load a single-cycle pulse after each load.
            r_ser_load <= 1'b0;
            if (w_decide) begin
                if (w_any) begin
                    r_state      <= ST_SHIFT;
                    r_cnt        <= LOG_WIDTH'(WIDTH - 1);
                    r_ser_load   <= 1'b1;
                    r_ser_din    <= w_gnt ? req1_data : req0_data;
                    r_grant_id   <= w_gnt;
                    r_is_sync    <= 1'b0;
                    r_last       <= w_gnt;
                    r_word_count <= r_word_count + 16'd1;
                end else if (sync_en) begin
                    r_state    <= ST_SHIFT;
                    r_cnt      <= LOG_WIDTH'(WIDTH - 1);
                    r_ser_load <= 1'b1;
                    r_ser_din  <= SYNC_WORD;
                    r_is_sync  <= 1'b1;
                end else begin
                    r_state <= ST_IDLE;
                end
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign ser_load   = r_ser_load;
    assign ser_din    = r_ser_din;
    assign grant_id   = r_grant_id;
    assign is_sync    = r_is_sync;
    assign busy       = (r_state == ST_SHIFT);
    assign word_count = r_word_count;

endmodule

// File: tb/tb_serializer_tx_sched.sv
// Scoreboard bench for serializer_tx_sched: stimulus queues expected loads and
// a negedge monitor compares every ser_load pulse, including load spacing.
`timescale 1ns/1ps
module tb_serializer_tx_sched;

    logic        clock_in = 1'b0;
    logic        reset_n;
    logic        sync_en;
    logic        req0_valid, req1_valid;
    logic [7:0]  req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        ser_load;
    logic [7:0]  ser_din;
    logic        grant_id, is_sync, busy;
    logic [15:0] word_count;

    serializer_tx_sched dut (
        .clock_in   (clock_in),
        .reset_n    (reset_n),
        .sync_en    (sync_en),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req0_ready (req0_ready),
        .req1_ready (req1_ready),
        .ser_load   (ser_load),
        .ser_din    (ser_din),
        .grant_id   (grant_id),
        .is_sync    (is_sync),
        .busy       (busy),
        .word_count (word_count)
    );

    always #5 clock_in = ~clock_in;

    typedef struct {
        logic [7:0]  din;
        logic        gid;
        logic        sync;
        logic [15:0] wc;
        int          gap;   // required cycles since previous load, 0 = unchecked
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    int   last_load_cyc = -1000;
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    task automatic push(input logic [7:0] din, input logic gid, input logic sync,
                        input logic [15:0] wc, input int gap);
        exp_t e;
        e.din = din; e.gid = gid; e.sync = sync; e.wc = wc; e.gap = gap;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock_in);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        sync_en    = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clock_in);
        #1 reset_n = 1'b1;
    endtask

    // Monitor: every load pulse must match the head of the scoreboard.
    always @(negedge clock_in) begin
        cyc++;
        if (reset_n === 1'b1 && ser_load === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_load", {24'd0, ser_din}, 32'hFFFF_FFFF);
            end else begin
                mon_e = sb_q.pop_front();
                check("load_din",  {24'd0, ser_din},    {24'd0, mon_e.din});
                check("load_gid",  {31'd0, grant_id},   {31'd0, mon_e.gid});
                check("load_sync", {31'd0, is_sync},    {31'd0, mon_e.sync});
                check("load_wc",   {16'd0, word_count}, {16'd0, mon_e.wc});
                if (mon_e.gap != 0)
                    check("load_gap", 32'(cyc - last_load_cyc), 32'(mon_e.gap));
            end
            last_load_cyc = cyc;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        req0_data = 8'h00;
        req1_data = 8'h00;

        // Reset state, with a valid request that must not be acknowledged.
        reset_n = 1'b0; sync_en = 1'b0; req0_valid = 1'b1; req1_valid = 1'b0;
        #12;
        check("rst_ready0", {31'd0, req0_ready}, 0);
        check("rst_load",   {31'd0, ser_load},   0);
        check("rst_din",    {24'd0, ser_din},    0);
        check("rst_busy",   {31'd0, busy},       0);
        check("rst_wc",     {16'd0, word_count}, 0);
        do_reset();

        // Single word from req0.
        req0_valid = 1'b1; req0_data = 8'hAA;
        push(8'hAA, 1'b0, 1'b0, 16'd1, 0);
        @(negedge clock_in);
        check("single_rdy0", {31'd0, req0_ready}, 1);
        check("single_rdy1", {31'd0, req1_ready}, 0);
        tick(); req0_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock_in);
            check("single_busy", {31'd0, busy}, 1);
        end
        @(negedge clock_in);
        check("single_idle", {31'd0, busy}, 0);

        // Contention: round-robin, req0 first after reset, loads 8 cycles apart.
        do_reset();
        req0_valid = 1'b1; req1_valid = 1'b1; req0_data = 8'hF0; req1_data = 8'h0F;
        push(8'hF0, 1'b0, 1'b0, 16'd1, 0);
        push(8'h0F, 1'b1, 1'b0, 16'd2, 8);
        push(8'hF0, 1'b0, 1'b0, 16'd3, 8);
        push(8'h0F, 1'b1, 1'b0, 16'd4, 8);
        for (int w = 0; w < 4; w++) begin
            @(negedge clock_in);
            check("rr_rdy0", {31'd0, req0_ready}, (w % 2 == 0) ? 1 : 0);
            check("rr_rdy1", {31'd0, req1_ready}, (w % 2 == 1) ? 1 : 0);
            if (w < 3) begin
                for (int k = 0; k < 7; k++) begin
                    @(negedge clock_in);
                    check("rr_shift_rdy", {30'd0, req0_ready, req1_ready}, 0);
                end
            end
        end
        tick(); req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (12) @(posedge clock_in);

        // Sync fill: three filler slots, then idle once sync_en drops.
        do_reset();
        sync_en = 1'b1;
        push(8'hBC, 1'b0, 1'b1, 16'd0, 0);
        push(8'hBC, 1'b0, 1'b1, 16'd0, 8);
        push(8'hBC, 1'b0, 1'b1, 16'd0, 8);
        @(negedge clock_in);
        check("sync_no_rdy", {30'd0, req0_ready, req1_ready}, 0);
        repeat (20) @(posedge clock_in);
        #1 sync_en = 1'b0;
        repeat (12) @(posedge clock_in);
        @(negedge clock_in);
        check("sync_idle", {31'd0, busy}, 0);
        check("sync_wc",   {16'd0, word_count}, 0);

        // Reset mid-slot abandons the word.
        do_reset();
        req0_valid = 1'b1; req0_data = 8'hCC;
        push(8'hCC, 1'b0, 1'b0, 16'd1, 0);
        tick(); req0_valid = 1'b0;
        repeat (4) @(posedge clock_in);
        #3 reset_n = 1'b0; req0_valid = 1'b1;
        #1;
        check("midrst_load",  {31'd0, ser_load},   0);
        check("midrst_din",   {24'd0, ser_din},    0);
        check("midrst_busy",  {31'd0, busy},       0);
        check("midrst_wc",    {16'd0, word_count}, 0);
        check("midrst_rdy0",  {31'd0, req0_ready}, 0);
        #19 reset_n = 1'b1; req0_valid = 1'b0;
        repeat (15) @(posedge clock_in);
        @(negedge clock_in);
        check("midrst_idle", {31'd0, busy}, 0);

        // Lone req1 after reset is granted despite history favouring req0.
        tick();
        req1_valid = 1'b1; req1_data = 8'h5A;
        push(8'h5A, 1'b1, 1'b0, 16'd1, 0);
        @(negedge clock_in);
        check("solo1_rdy1", {31'd0, req1_ready}, 1);
        check("solo1_rdy0", {31'd0, req0_ready}, 0);
        tick(); req1_valid = 1'b0;
        repeat (10) @(posedge clock_in);

        // Valid arriving mid-shift waits for the next decision cycle.
        #1 req0_valid = 1'b1; req0_data = 8'h33;
        push(8'h33, 1'b0, 1'b0, 16'd2, 0);
        push(8'h44, 1'b1, 1'b0, 16'd3, 8);
        @(negedge clock_in);
        check("ign_rdy0", {31'd0, req0_ready}, 1);
        tick(); req0_valid = 1'b0; req0_data = 8'h99;
        tick();
        tick(); req1_valid = 1'b1; req1_data = 8'h44;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock_in);
            check("ign_rdy1_low", {31'd0, req1_ready}, 0);
        end
        @(negedge clock_in);
        check("ign_rdy1_high", {31'd0, req1_ready}, 1);
        tick(); req1_valid = 1'b0;
        repeat (12) @(posedge clock_in);

        @(negedge clock_in);
        check("sb_empty", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
